rpn_stack_evaluator: RTL and testbench



---
 rtl/rpn_pkg.sv | 25 ++
 rtl/rpn_alu.sv | 24 ++
 rtl/rpn_stack_evaluator.sv | 148 ++++++++++++++
 tb/tb_rpn_stack_evaluator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared types and defaults for the RPN stack evaluator.
package rpn_pkg;

    localparam int unsigned RPN_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_XOR = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_UNDERFLOW = 2'b01,
        ERR_OVERFLOW  = 2'b10,
        ERR_LEFTOVER  = 2'b11
    } err_t;

    typedef enum logic [3:0] {
        IDLE, PUSH, PEEK_B, POP_B, PEEK_A, POP_A, EXEC,
        FIN_PEEK, FIN_POP, FIN_CHK, SKIP, FLUSH, DONE
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational A op B unit; all results wrap modulo 2^DATA_WIDTH.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RPN_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  opcode_t               op,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_MUL: y = a * b;
            OP_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_evaluator.sv
// Postfix expression engine; sole master of an external LIFO stack.
module rpn_stack_evaluator
    import rpn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RPN_DATA_WIDTH
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Tok_Valid_In,
    output logic                  Tok_Ready_Out,
    input  logic                  Tok_Is_Op_In,
    input  logic [DATA_WIDTH-1:0] Tok_Data_In,
    input  logic                  Tok_Last_In,
    output logic [DATA_WIDTH-1:0] Stk_Data_Out,
    output logic                  Stk_Push_Out,
    output logic                  Stk_Pop_Out,
    output logic                  Stk_Peek_Out,
    input  logic [DATA_WIDTH-1:0] Stk_Data_In,
    input  logic                  Stk_Empty_In,
    input  logic                  Stk_Full_In,
    output logic [DATA_WIDTH-1:0] Result_Out,
    output logic                  Result_Valid_Out,
    output logic [1:0]            Error_Out
);

    state_t                state_q, state_nxt;
    err_t                  err_q, err_raise;
    logic [DATA_WIDTH-1:0] tok_data_q, a_q, b_q, res_q, alu_y;
    logic                  tok_last_q;
    logic                  accept;

    rpn_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (opcode_t'(tok_data_q[1:0])),
        .y  (alu_y)
    );

    assign accept = Tok_Valid_In && Tok_Ready_Out;

    always_comb begin
        state_nxt = state_q;
        err_raise = ERR_OK;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!Tok_Is_Op_In) begin
                        if (Stk_Full_In) begin
                            err_raise = ERR_OVERFLOW;
                            state_nxt = Tok_Last_In ? FLUSH : SKIP;
                        end else begin
                            state_nxt = PUSH;
                        end
                    end else if (Stk_Empty_In) begin
                        err_raise = ERR_UNDERFLOW;
                        state_nxt = Tok_Last_In ? FLUSH : SKIP;
                    end else begin
                        state_nxt = PEEK_B;
                    end
                end
            end
            PUSH, EXEC: state_nxt = tok_last_q ? FIN_PEEK : IDLE;
            PEEK_B:     state_nxt = POP_B;
            POP_B:      state_nxt = PEEK_A;
            PEEK_A: begin
                if (Stk_Empty_In) begin
                    err_raise = ERR_UNDERFLOW;
                    state_nxt = tok_last_q ? FLUSH : SKIP;
                end else begin
                    state_nxt = POP_A;
                end
            end
            POP_A:      state_nxt = EXEC;
            FIN_PEEK: begin
                if (Stk_Empty_In) begin
                    err_raise = ERR_UNDERFLOW;
                    state_nxt = FLUSH;
                end else begin
                    state_nxt = FIN_POP;
                end
            end
            FIN_POP:    state_nxt = FIN_CHK;
            FIN_CHK: begin
                if (!Stk_Empty_In) begin
                    err_raise = ERR_LEFTOVER;
                    state_nxt = FLUSH;
                end else begin
                    state_nxt = DONE;
                end
            end
            SKIP:       if (accept && Tok_Last_In) state_nxt = FLUSH;
            FLUSH:      if (Stk_Empty_In) state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Stack strobes decode the current state so FLUSH can pop back-to-back
    // on the live empty flag without overshooting.
    always_comb begin
        Stk_Push_Out = (state_q == PUSH) || (state_q == EXEC);
        Stk_Peek_Out = (state_q == PEEK_B)
                    || (((state_q == PEEK_A) || (state_q == FIN_PEEK)) && !Stk_Empty_In);
        Stk_Pop_Out  = (state_q == POP_B) || (state_q == POP_A) || (state_q == FIN_POP)
                    || ((state_q == FLUSH) && !Stk_Empty_In);
        Stk_Data_Out = '0;
        if (state_q == PUSH)      Stk_Data_Out = tok_data_q;
        else if (state_q == EXEC) Stk_Data_Out = alu_y;
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q          <= IDLE;
            err_q            <= ERR_OK;
            tok_data_q       <= '0;
            tok_last_q       <= 1'b0;
            a_q              <= '0;
            b_q              <= '0;
            res_q            <= '0;
            Tok_Ready_Out    <= 1'b0;
            Result_Out       <= '0;
            Result_Valid_Out <= 1'b0;
            Error_Out        <= ERR_OK;
        end else begin
            state_q          <= state_nxt;
            Tok_Ready_Out    <= (state_nxt == IDLE) || (state_nxt == SKIP);
            Result_Valid_Out <= (state_nxt == DONE);
            if (state_q == IDLE && accept) begin
                tok_data_q <= Tok_Data_In;
                tok_last_q <= Tok_Last_In;
            end
            if (state_q == POP_B)   b_q   <= Stk_Data_In;
            if (state_q == POP_A)   a_q   <= Stk_Data_In;
            if (state_q == FIN_POP) res_q <= Stk_Data_In;
            if (state_q == DONE) begin
                err_q <= ERR_OK;
            end else if (err_q == ERR_OK && err_raise != ERR_OK) begin
                err_q <= err_raise;
            end
            // DONE is only entered from FIN_CHK (clean) or FLUSH (error already latched).
            if (state_nxt == DONE) begin
                Result_Out <= (err_q == ERR_OK) ? res_q : '0;
                Error_Out  <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_rpn_stack_evaluator.sv
// Bench for rpn_stack_evaluator with a behavioural 16-bit, 8-deep stack and a result scoreboard.
module tb_rpn_stack_evaluator;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tv = 1'b0, t_op = 1'b0, t_last = 1'b0;
    logic [DW-1:0] td = '0;
    logic          ready, push, pop, peek, valid, empty, full;
    logic [DW-1:0] stk_din, stk_q, res;
    logic [1:0]    err;

    always #5 clk = ~clk;

    rpn_stack_evaluator #(.DATA_WIDTH(DW)) dut (
        .Clk_In           (clk),
        .Reset_In         (rst_n),
        .Tok_Valid_In     (tv),
        .Tok_Ready_Out    (ready),
        .Tok_Is_Op_In     (t_op),
        .Tok_Data_In      (td),
        .Tok_Last_In      (t_last),
        .Stk_Data_Out     (stk_din),
        .Stk_Push_Out     (push),
        .Stk_Pop_Out      (pop),
        .Stk_Peek_Out     (peek),
        .Stk_Data_In      (stk_q),
        .Stk_Empty_In     (empty),
        .Stk_Full_In      (full),
        .Result_Out       (res),
        .Result_Valid_Out (valid),
        .Error_Out        (err)
    );

    // Stack model: push writes at the edge, peek shows the top next cycle, flags are post-edge.
    logic [DW-1:0] stk_mem [8];
    logic [3:0]    stk_cnt;
    logic [2:0]    top_idx;
    assign top_idx = stk_cnt[2:0] - 3'd1;
    assign empty   = (stk_cnt == 4'd0);
    assign full    = (stk_cnt == 4'd8);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_cnt <= 4'd0;
            stk_q   <= '0;
        end else if (push && !full) begin
            stk_mem[stk_cnt[2:0]] <= stk_din;
            stk_cnt <= stk_cnt + 4'd1;
        end else if (pop && !empty) begin
            stk_cnt <= stk_cnt - 4'd1;
        end else if (peek && !empty) begin
            stk_q <= stk_mem[top_idx];
        end
    end

    typedef struct {
        logic [DW-1:0] res;
        logic [1:0]    err;
        int            pops;
        int            lat;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   errors = 0, checks = 0;
    int   cyc = 0, pop_total = 0, pop_base = 0, last_push = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic expect_result(input logic [DW-1:0] r, input logic [1:0] e, input int pops, input int lat);
        exp_t x;
        x.res = r; x.err = e; x.pops = pops; x.lat = lat;
        sb.push_back(x);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each result pulse.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pop_base = pop_total;
        end else begin
            if (pop)  pop_total++;
            if (push) last_push = cyc;
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got result %0h err %0d expected no pulse", res, err);
                end else begin
                    e_cur = sb.pop_front();
                    chk("result", 32'(res), 32'(e_cur.res));
                    chk("error", 32'(err), 32'(e_cur.err));
                    chk("stack_empty", 32'(stk_cnt), 32'd0);
                    chk("pop_count", 32'(pop_total - pop_base), 32'(e_cur.pops));
                    if (e_cur.lat >= 0) chk("latency", 32'(cyc - last_push), 32'(e_cur.lat));
                end
                pop_base = pop_total;
            end
        end
    end

    task automatic send(input logic is_op, input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        tv = 1'b1; t_op = is_op; td = d; t_last = last;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready 0 expected 1 for token %0h", d);
        end
        @(posedge clk);
        #1 tv = 1'b0;
    endtask

    task automatic operand(input logic [DW-1:0] d, input logic last);
        send(1'b0, d, last);
    endtask

    task automatic operator(input logic [1:0] op, input logic last);
        send(1'b1, {{(DW-2){1'b0}}, op}, last);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_result", 32'(res), 32'd0);
        chk("rst_error", 32'(err), 32'd0);
        chk("rst_strobes", 32'({push, pop, peek}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(ready), 32'd0);
        @(posedge clk);
        #1 chk("ready_after_release", 32'(ready), 32'd1);

        // 3 4 + 2 * = 14
        expect_result(16'd14, 2'b00, 5, 4);
        operand(16'd3, 0); operand(16'd4, 0); operator(2'b00, 0);
        operand(16'd2, 0); operator(2'b10, 1);

        expect_result(16'd7, 2'b00, 3, 4);
        operand(16'd10, 0); operand(16'd3, 0); operator(2'b01, 1);

        expect_result(16'h0000, 2'b00, 3, 4);
        operand(16'h0100, 0); operand(16'h0100, 0); operator(2'b10, 1);

        expect_result(16'h0000, 2'b00, 3, 4);
        operand(16'hFFFF, 0); operand(16'h0001, 0); operator(2'b00, 1);

        // 5 + : B pops, A underflows
        expect_result(16'h0000, 2'b01, 1, -1);
        operand(16'd5, 0); operator(2'b00, 1);

        // 9th operand overflows, 10th (Last) is skipped, 8 entries flushed
        expect_result(16'h0000, 2'b10, 8, -1);
        for (int i = 1; i <= 10; i++) operand(16'(i), (i == 10));

        // 1 2 : one value left over after the result pop
        expect_result(16'h0000, 2'b11, 2, -1);
        operand(16'd1, 0); operand(16'd2, 1);

        expect_result(16'd1, 2'b00, 3, 4);
        operand(16'd6, 0); operand(16'd7, 0); operator(2'b11, 1);
        wait_drain();

        // Abort during POP_A of 3 4 +
        operand(16'd3, 0); operand(16'd4, 0); operator(2'b00, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pop_a_strobe", 32'(pop), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_result", 32'(res), 32'd0);
        chk("abort_error", 32'(err), 32'd0);
        chk("abort_strobes", 32'({push, pop, peek}), 32'd0);
        chk("abort_stack", 32'(stk_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        expect_result(16'd8, 2'b00, 1, 4);
        operand(16'd8, 1);
        wait_drain();
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
